// File: rtl/match_controller_pkg.sv
// ---------------------------------------------------------------------------
// match_controller_pkg : shared state encoding and target-score table
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package match_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_PAUSE      = 3'd3,
    ST_OVER       = 3'd4
  } state_t;

  localparam logic [3:0] c_tgt_sel0 = 4'd3;
  localparam logic [3:0] c_tgt_sel1 = 4'd5;
  localparam logic [3:0] c_tgt_sel2 = 4'd7;
  localparam logic [3:0] c_tgt_sel3 = 4'd11;

  function automatic logic [3:0] target_of(input logic [1:0] sel);
    logic [3:0] tgt;
    case (sel)
      2'd0:    tgt = c_tgt_sel0;
      2'd1:    tgt = c_tgt_sel1;
      2'd2:    tgt = c_tgt_sel2;
      default: tgt = c_tgt_sel3;
    endcase
    return tgt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/match_controller_timer.sv
// ---------------------------------------------------------------------------
// match_timer : loadable down-counter, done while enabled and at zero
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module match_timer
  import match_controller_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_done
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = i_en && (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/match_controller.sv
// ---------------------------------------------------------------------------
// match_controller : N-player serve/score/win controller for the paddle game
// Optional build macro MATCH_WIN_BY_TWO_EN enables win-by-two with deuce.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module match_controller
  import match_controller_pkg::*;
#(
  parameter int NUM_PLAYERS        = 2,
  parameter int SCORE_W            = 4,
  parameter int AUTO_SERVE_CYCLES  = 50000000,
  parameter int POINT_PAUSE_CYCLES = 25000000,
  parameter int IDX_W              = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           serve,
  input  logic                           serve_type,
  input  logic [1:0]                     max_score,
  input  logic                           goal_valid,
  input  logic [IDX_W-1:0]               goal_player,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [IDX_W-1:0]               server,
  output logic                           ball_release,
  output logic                           in_play,
  output logic                           point_pulse,
  output logic                           game_over,
  output logic [IDX_W-1:0]               winner
);

  localparam int TMR_MAX = (AUTO_SERVE_CYCLES > POINT_PAUSE_CYCLES) ?
                           AUTO_SERVE_CYCLES : POINT_PAUSE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0]   c_auto_load  = TMR_W'(AUTO_SERVE_CYCLES - 1);
  localparam logic [TMR_W-1:0]   c_pause_load = TMR_W'(POINT_PAUSE_CYCLES - 1);
  localparam logic [SCORE_W-1:0] c_score_max  = '1;
  localparam logic [IDX_W-1:0]   c_last_idx   = IDX_W'(NUM_PLAYERS - 1);

  generate
    if (SCORE_W < 4) begin : g_chk_score_w
      $error("match_controller: SCORE_W must be at least 4");
    end
    if ((NUM_PLAYERS < 2) || (NUM_PLAYERS > 4)) begin : g_chk_players
      $error("match_controller: NUM_PLAYERS must be 2..4");
    end
  endgenerate

  state_t             r_state;
  logic [SCORE_W-1:0] r_score [NUM_PLAYERS];
  logic [SCORE_W-1:0] r_target;
  logic               r_auto;
  logic [IDX_W-1:0]   r_server;
  logic [IDX_W-1:0]   r_winner;
  logic               r_ball_release;

  logic [IDX_W-1:0]   w_gp;
  logic               w_idx_ok;
  logic               w_goal_ok;
  logic [SCORE_W-1:0] w_goal_score;
  logic               w_win;
  logic [IDX_W-1:0]   w_win_idx;
  logic               w_tmr_load;
  logic [TMR_W-1:0]   w_tmr_val;
  logic               w_tmr_en;
  logic               w_tmr_done;

  generate
    if ((1 << IDX_W) == NUM_PLAYERS) begin : g_idx_full
      assign w_idx_ok = 1'b1;
    end else begin : g_idx_part
      assign w_idx_ok = (32'(goal_player) < NUM_PLAYERS);
    end
  endgenerate

  assign w_gp         = w_idx_ok ? goal_player : '0;
  assign w_goal_ok    = (r_state == ST_PLAY) && goal_valid && w_idx_ok;
  assign w_goal_score = (r_score[w_gp] == c_score_max) ? r_score[w_gp]
                                                       : r_score[w_gp] + 1'b1;

`ifdef MATCH_WIN_BY_TWO_EN
  logic [SCORE_W-1:0] w_best;
  logic [SCORE_W-1:0] w_cand;

  always_comb begin
    w_best    = '0;
    w_cand    = '0;
    w_win_idx = w_gp;
    w_win     = (w_goal_score >= r_target);
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if ((IDX_W'(i) != w_gp) &&
          ({1'b0, w_goal_score} < ({1'b0, r_score[i]} + (SCORE_W + 1)'(2)))) begin
        w_win = 1'b0;
      end
    end
    // A saturated score can no longer open a lead, so the leader wins outright
    if (w_goal_score == c_score_max) begin
      w_win     = 1'b1;
      w_win_idx = '0;
      w_best    = (w_gp == '0) ? w_goal_score : r_score[0];
      for (int i = 1; i < NUM_PLAYERS; i++) begin
        w_cand = (IDX_W'(i) == w_gp) ? w_goal_score : r_score[i];
        if (w_cand > w_best) begin
          w_best    = w_cand;
          w_win_idx = IDX_W'(i);
        end
      end
    end
  end
`else
  always_comb begin
    w_win_idx = w_gp;
    w_win     = (w_goal_score >= r_target);
  end
`endif

  // Timer is preloaded for whichever timed state comes next, so it is
  // already armed on the entry edge of SERVE_WAIT or PAUSE.
  assign w_tmr_en   = (r_state == ST_PAUSE) || ((r_state == ST_SERVE_WAIT) && r_auto);
  assign w_tmr_load = w_tmr_done ||
                      !((r_state == ST_PAUSE) || (r_state == ST_SERVE_WAIT));
  assign w_tmr_val  = (r_state == ST_PLAY) ? c_pause_load : c_auto_load;

  match_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_en       (w_tmr_en),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_target       <= '0;
      r_auto         <= 1'b0;
      r_server       <= '0;
      r_winner       <= '0;
      r_ball_release <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= '0;
    end else begin
      r_ball_release <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            r_state  <= ST_SERVE_WAIT;
            r_target <= SCORE_W'(target_of(max_score));
            r_auto   <= serve_type;
            r_server <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= '0;
          end
        end
        ST_SERVE_WAIT: begin
          if (serve || (r_auto && w_tmr_done)) begin
            r_state        <= ST_PLAY;
            r_ball_release <= 1'b1;
          end
        end
        ST_PLAY: begin
          if (w_goal_ok) begin
            r_score[w_gp] <= w_goal_score;
            if (w_win) begin
              r_state  <= ST_OVER;
              r_winner <= w_win_idx;
            end else begin
              r_state  <= ST_PAUSE;
              r_server <= (r_server == c_last_idx) ? '0 : r_server + 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (w_tmr_done) r_state <= ST_SERVE_WAIT;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  generate
    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_pack
      assign score[g*SCORE_W +: SCORE_W] = r_score[g];
    end
  endgenerate

  assign server       = r_server;
  assign winner       = r_winner;
  assign ball_release = r_ball_release;
  assign in_play      = (r_state == ST_PLAY);
  assign game_over    = (r_state == ST_OVER);
  assign point_pulse  = w_goal_ok;

endmodule

`default_nettype wire

// File: tb/tb_match_controller.sv
// ---------------------------------------------------------------------------
// tb_match_controller : randomized match play against a rules-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_match_controller;

  localparam int NP    = 3;
  localparam int SW    = 4;
  localparam int AUTO  = 8;
  localparam int PAUSE = 4;
  localparam int IW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          serve = 1'b0;
  logic          serve_type = 1'b0;
  logic [1:0]    max_score = 2'd0;
  logic          goal_valid = 1'b0;
  logic [IW-1:0] goal_player = '0;
  logic [NP*SW-1:0] score;
  logic [IW-1:0] server;
  logic [IW-1:0] winner;
  logic          ball_release, in_play, point_pulse, game_over;

  always #5 clk = ~clk;

  match_controller #(
    .NUM_PLAYERS        (NP),
    .SCORE_W            (SW),
    .AUTO_SERVE_CYCLES  (AUTO),
    .POINT_PAUSE_CYCLES (PAUSE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .serve        (serve),
    .serve_type   (serve_type),
    .max_score    (max_score),
    .goal_valid   (goal_valid),
    .goal_player  (goal_player),
    .score        (score),
    .server       (server),
    .ball_release (ball_release),
    .in_play      (in_play),
    .point_pulse  (point_pulse),
    .game_over    (game_over),
    .winner       (winner)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // rules-level match model
  int m_score [NP];
  int m_target;
  int m_server;
  int m_winner;
  bit m_auto;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int target_for(input logic [1:0] sel);
    int t;
    case (sel)
      2'd0: t = 3;
      2'd1: t = 5;
      2'd2: t = 7;
      default: t = 11;
    endcase
    return t;
  endfunction

  // Match-config inputs only matter on the start cycle; scramble them otherwise.
  task automatic scramble_cfg();
    max_score  = 2'($urandom);
    serve_type = 1'($urandom);
  endtask

  task automatic check_scores(input string tag);
    for (int i = 0; i < NP; i++)
      check($sformatf("%s score[%0d]", tag, i), 32'(score[i*SW +: SW]), m_score[i]);
  endtask

  task automatic model_goal(input int p, output bit over);
    if (m_score[p] < (1 << SW) - 1) m_score[p]++;
    m_winner = p;
`ifdef MATCH_WIN_BY_TWO_EN
    if (m_score[p] == (1 << SW) - 1) begin
      m_winner = 0;
      for (int i = 1; i < NP; i++)
        if (m_score[i] > m_score[m_winner]) m_winner = i;
      over = 1'b1;
    end else begin
      over = (m_score[p] >= m_target);
      for (int q = 0; q < NP; q++)
        if (q != p && m_score[p] - m_score[q] < 2) over = 1'b0;
    end
`else
    over = (m_score[p] >= m_target);
`endif
  endtask

  task automatic start_match(input logic [1:0] sel, input bit auto_mode);
    start      = 1'b1;
    max_score  = sel;
    serve_type = auto_mode;
    tick();
    start = 1'b0;
    scramble_cfg();
    m_target = target_for(sel);
    m_auto   = auto_mode;
    m_server = 0;
    for (int i = 0; i < NP; i++) m_score[i] = 0;
    check_scores("start");
    check("start server", server, 0);
    check("start game_over", game_over, 0);
    check("start in_play", in_play, 0);
  endtask

  // Entered one negedge after SERVE_WAIT entry; leaves one cycle into PLAY.
  task automatic serve_phase();
    int d;
    int early;
    bit exp_rel;
    if (!m_auto) begin
      d = $urandom_range(0, 3);
      for (int c = 0; c < d; c++) begin
        goal_valid  = 1'($urandom);
        goal_player = IW'($urandom_range(0, NP - 1));
        #1 check("sw point_pulse", point_pulse, 0);
        tick();
        goal_valid = 1'b0;
        check("sw no release", ball_release, 0);
        check("sw in_play", in_play, 0);
      end
      serve       = 1'b1;
      goal_valid  = 1'($urandom);
      goal_player = IW'($urandom_range(0, NP - 1));
      #1 check("serve+goal point_pulse", point_pulse, 0);
      tick();
      serve      = 1'b0;
      goal_valid = 1'b0;
      check("manual release", ball_release, 1);
      check("manual in_play", in_play, 1);
      check_scores("after serve");
    end else begin
      early = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, AUTO - 2)) : -1;
      for (int c = 1; c <= AUTO; c++) begin
        if (c - 1 == early) serve = 1'b1;
        goal_valid  = 1'($urandom);
        goal_player = IW'($urandom_range(0, NP - 1));
        tick();
        serve      = 1'b0;
        goal_valid = 1'b0;
        exp_rel = (early >= 0) ? (c == early + 1) : (c == AUTO);
        check($sformatf("auto release c=%0d", c), ball_release, exp_rel);
        if (exp_rel) break;
      end
      check_scores("after auto serve");
    end
    tick();
    check("release width", ball_release, 0);
    check("play in_play", in_play, 1);
  endtask

  task automatic play_point(input int p, output bit over);
    int d;
    d = $urandom_range(0, 2);
    for (int c = 0; c < d; c++) begin
      start       = 1'($urandom);
      serve       = 1'($urandom);
      goal_valid  = 1'($urandom);
      goal_player = IW'(3);
      #1 check("invalid goal pulse", point_pulse, 0);
      tick();
      start = 1'b0; serve = 1'b0; goal_valid = 1'b0;
      check("ignored in_play", in_play, 1);
      check_scores("ignored events");
    end
    goal_valid  = 1'b1;
    goal_player = IW'(p);
    #1 check("goal point_pulse", point_pulse, 1);
    tick();
    goal_valid = 1'b0;
    model_goal(p, over);
    check_scores("goal");
    check("goal game_over", game_over, over);
    check("goal in_play", in_play, 0);
    if (over) begin
      check("winner", winner, m_winner);
    end else begin
      m_server = (m_server + 1) % NP;
      check("server rotate", server, m_server);
      for (int c = 0; c < PAUSE; c++) begin
        serve       = 1'($urandom);
        goal_valid  = 1'($urandom);
        goal_player = IW'($urandom_range(0, NP - 1));
        tick();
        serve = 1'b0; goal_valid = 1'b0;
        check("pause no release", ball_release, 0);
        check("pause in_play", in_play, 0);
      end
      check("pause server", server, m_server);
    end
  endtask

  task automatic over_hold();
    for (int c = 0; c < 2; c++) begin
      serve       = 1'($urandom);
      goal_valid  = 1'b1;
      goal_player = IW'($urandom_range(0, NP - 1));
      #1 check("over point_pulse", point_pulse, 0);
      tick();
      serve = 1'b0; goal_valid = 1'b0;
      check("over held", game_over, 1);
      check("over winner", winner, m_winner);
    end
    check_scores("over hold");
  endtask

  task automatic run_seq(input logic [1:0] sel, input bit auto_mode,
                         input int seq [8], input int len);
    bit over;
    over = 1'b0;
    start_match(sel, auto_mode);
    for (int k = 0; k < len && !over; k++) begin
      serve_phase();
      play_point(seq[k], over);
    end
    check("seq ends in game_over", game_over, 1);
  endtask

  task automatic random_match(input logic [1:0] sel, input bit auto_mode);
    bit over;
    int fav;
    int p;
    int pts;
    over = 1'b0;
    pts  = 0;
    fav  = $urandom_range(0, NP - 1);
    start_match(sel, auto_mode);
    while (!over && pts < 60) begin
      serve_phase();
      p = ($urandom_range(0, 1) == 1) ? fav : int'($urandom_range(0, NP - 1));
      play_point(p, over);
      pts++;
    end
    check("match terminates", over, 1);
    over_hold();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " score"}, 32'(score), 0);
    check({tag, " server"}, server, 0);
    check({tag, " winner"}, winner, 0);
    check({tag, " ball_release"}, ball_release, 0);
    check({tag, " in_play"}, in_play, 0);
    check({tag, " point_pulse"}, point_pulse, 0);
    check({tag, " game_over"}, game_over, 0);
  endtask

  task automatic reset_test();
    bit over;
    start_match(2'd3, 1'b0);
    for (int k = 0; k < 2; k++) begin
      serve_phase();
      play_point(0, over);
    end
    serve_phase();
    check("pre-reset score0", 32'(score[SW-1:0]), 2);
    rst_n = 1'b0;
    #1 check_all_zero("async reset");
    tick();
    check_all_zero("held reset");
    rst_n = 1'b1;
    serve       = 1'b1;
    goal_valid  = 1'b1;
    goal_player = IW'(1);
    #1 check("idle point_pulse", point_pulse, 0);
    tick();
    serve = 1'b0; goal_valid = 1'b0;
    check_all_zero("idle after reset");
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int seq_a [8];
    int seq_b [8];
    seq_a = '{1, 1, 1, 0, 0, 0, 0, 0};
    seq_b = '{0, 1, 0, 1, 0, 1, 0, 0};
    m_winner = 0;
    tick();
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    run_seq(2'd0, 1'b0, seq_a, 3);
    check("directed p1 score", 32'(score[2*SW-1:SW]), 3);
    check("directed winner", winner, 1);
    over_hold();

    random_match(2'd1, 1'b0);
    random_match(2'd0, 1'b1);
    for (int k = 0; k < 6; k++) random_match(2'($urandom), 1'($urandom));

    run_seq(2'd0, 1'b0, seq_b, 8);
    over_hold();

    reset_test();
    random_match(2'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
